// File: rtl/fir_decim_out.sv
// Decimating requantizer with output FIFO for the transposed FIR: keeps every DECIM-th valid sample,
// rounds/shifts/saturates it to outWL bits and buffers it behind a valid/ready port. Optional sat_cnt via FIR_DECIM_SAT_CNT_EN.
module fir_decim_out #(
    parameter int macWL      = 20,
    parameter int outWL      = 16,
    parameter int SHIFT      = 4,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic signed [macWL-1:0]           data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [outWL-1:0]           data_out,
    output logic                              sat_flag,
    output logic                              drop_flag,
    output logic [$clog2(FIFO_DEPTH):0]       level
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    output logic [15:0]                       sat_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [macWL:0]   HALF = (macWL+1)'(2 ** (SHIFT - 1));
    localparam logic signed [macWL:0]   MAXV = (macWL+1)'(2 ** (outWL - 1) - 1);
    localparam logic signed [macWL:0]   MINV = (macWL+1)'(-(2 ** (outWL - 1)));
    localparam logic signed [outWL-1:0] MAXO = {1'b0, {(outWL-1){1'b1}}};
    localparam logic signed [outWL-1:0] MINO = {1'b1, {(outWL-1){1'b0}}};

    // Round half-up then arithmetic shift; one guard bit keeps the +HALF from overflowing.
    function automatic logic signed [macWL:0] rnd_shift(input logic signed [macWL-1:0] x);
        logic signed [macWL:0] t;
        t = {x[macWL-1], x} + HALF;
        return t >>> SHIFT;
    endfunction

    function automatic logic is_sat(input logic signed [macWL:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [outWL-1:0] sat_clip(input logic signed [macWL:0] r);
        if (r > MAXV)      return MAXO;
        else if (r < MINV) return MINO;
        else               return r[outWL-1:0];
    endfunction

    logic [PW-1:0]            phase_q, phase_d;
    logic [AW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic signed [outWL-1:0]  mem_q [FIFO_DEPTH];
    logic signed [outWL-1:0]  dout_q, dout_d;
    logic                     sat_flag_q, sat_flag_d;
    logic                     drop_q, drop_d;

    logic signed [macWL:0]    rs;
    logic signed [outWL-1:0]  wdata;
    logic                     wsat;
    logic                     keep, full, empty, push, pop;
    logic [AW:0]              cnt;
    logic [AW-1:0]            rd_idx_nxt;

    always_comb begin
        rs         = rnd_shift(data_in);
        wdata      = sat_clip(rs);
        wsat       = is_sat(rs);
        cnt        = wr_ptr_q - rd_ptr_q;
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        keep       = in_valid && (phase_q == '0);
        pop        = !empty && out_ready;
        push       = keep && (!full || pop);
        rd_idx_nxt = rd_ptr_q[AW-1:0] + AW'(1);

        phase_d = phase_q;
        if (in_valid)
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);

        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        // data_out is a register so it can hold the last popped word once the FIFO drains.
        dout_d = dout_q;
        if (pop) begin
            if (cnt > (AW+1)'(1))
                dout_d = mem_q[rd_idx_nxt];
            else if (push)
                dout_d = wdata;
        end else if (empty && push) begin
            dout_d = wdata;
        end

        sat_flag_d = push && wsat;
        drop_d     = drop_q || (keep && !push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            sat_flag_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            sat_flag_q <= sat_flag_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt_q <= '0;
        else if (push && wsat && (sat_cnt_q != 16'hFFFF))
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_cnt = sat_cnt_q;
`endif

    assign out_valid = !empty;
    assign data_out  = dout_q;
    assign sat_flag  = sat_flag_q;
    assign drop_flag = drop_q;
    assign level     = cnt;

endmodule

// File: tb/tb_fir_decim_out.sv
// Randomized bench for fir_decim_out against a queue-based reference model of decimate/requantize/FIFO.
module tb_fir_decim_out;

    localparam int macWL = 20;
    localparam int outWL = 16;
    localparam int SHIFT = 4;
    localparam int DECIM = 2;
    localparam int DEPTH = 8;

    logic                         clk;
    logic                         rst_n;
    logic                         in_valid;
    logic [macWL-1:0]             data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [outWL-1:0]             data_out;
    logic                         sat_flag;
    logic                         drop_flag;
    logic [$clog2(DEPTH):0]       level;
`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0]                  sat_cnt;
`endif

    fir_decim_out #(
        .macWL(macWL), .outWL(outWL), .SHIFT(SHIFT), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .sat_flag(sat_flag),
        .drop_flag(drop_flag),
        .level(level)
`ifdef FIR_DECIM_SAT_CNT_EN
        ,
        .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: kept words in order, count of valid samples, last word shown.
    int mq[$];
    int vcnt;
    int exp_dout;
    int exp_drop;
    int exp_sat;
    int exp_satcnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        vcnt       = 0;
        exp_dout   = 0;
        exp_drop   = 0;
        exp_sat    = 0;
        exp_satcnt = 0;
    endfunction

    // floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp to the output range.
    function automatic int quant(input int x, output int sat);
        int r;
        int hi;
        int lo;
        hi  = (1 << (outWL - 1)) - 1;
        lo  = -(1 << (outWL - 1));
        r   = (x + (1 << (SHIFT - 1))) >>> SHIFT;
        sat = 0;
        if (r > hi) begin r = hi; sat = 1; end
        if (r < lo) begin r = lo; sat = 1; end
        return r;
    endfunction

    function automatic void model_edge();
        bit pop, keep;
        int q, s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop  = (mq.size() > 0) && out_ready;
        keep = in_valid && ((vcnt % DECIM) == 0);
        if (in_valid) vcnt++;
        if (pop) void'(mq.pop_front());
        exp_sat = 0;
        if (keep) begin
            q = quant($signed(data_in), s);
            if (mq.size() < DEPTH) begin
                mq.push_back(q);
                exp_sat = s;
                if (s != 0 && exp_satcnt < 65535) exp_satcnt++;
            end else begin
                exp_drop = 1;
            end
        end
        if (mq.size() > 0) exp_dout = mq[0];
    endfunction

    task automatic check_all();
        chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
        chk("level", int'(level), mq.size());
        chk("data_out", int'($signed(data_out)), exp_dout);
        chk("drop_flag", int'(drop_flag), exp_drop);
        chk("sat_flag", int'(sat_flag), exp_sat);
`ifdef FIR_DECIM_SAT_CNT_EN
        chk("sat_cnt", int'(sat_cnt), exp_satcnt);
`endif
    endtask

    // Drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input int d, input logic rdy);
        in_valid  = v;
        data_in   = macWL'(d);
        out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    function automatic int rnd_data();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 40)) + 524247;
            1:       return -524288 + int'($urandom_range(0, 40));
            2:       return int'($urandom_range(0, 200)) - 100;
            default: return $signed(macWL'($urandom));
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle(1'b0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int rnd_v [7];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held for 100 ns with random input activity.
        for (int i = 0; i < 10; i++) cycle(1'($urandom), rnd_data(), 1'($urandom));
        chk("rst_level", int'(level), 0);
        chk("rst_dout", int'($signed(data_out)), 0);
        rst_n = 1'b1;
        cycle(1'b1, 100, 1'b1);
        chk("first_lat_valid", int'(out_valid), 1);
        chk("first_lat_data", int'($signed(data_out)), 6);
        cycle(1'b1, 0, 1'b1);

        // Rounding ties and negative rounding.
        foreach (rnd_v[i]) rnd_v[i] = 0;
        cycle(1'b1, 24, 1'b1);  chk("rnd_24", int'($signed(data_out)), 2);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 23, 1'b1);  chk("rnd_23", int'($signed(data_out)), 1);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, -24, 1'b1); chk("rnd_m24", int'($signed(data_out)), -1);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, -25, 1'b1); chk("rnd_m25", int'($signed(data_out)), -2);
        cycle(1'b1, 0, 1'b1);

        // Saturation at both rails.
        do_reset();
        cycle(1'b1, 524287, 1'b1);  chk("sat_pos", int'($signed(data_out)), 32767);
        chk("sat_pos_flag", int'(sat_flag), 1);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 524280, 1'b1);  chk("sat_pos2", int'($signed(data_out)), 32767);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, -524288, 1'b1); chk("sat_neg", int'($signed(data_out)), -32768);
        chk("sat_neg_flag", int'(sat_flag), 0);
        cycle(1'b1, 0, 1'b1);
`ifdef FIR_DECIM_SAT_CNT_EN
        chk("sat_cnt_two", int'(sat_cnt), 2);
`endif

        // Gapped in_valid: phase only advances on valid cycles.
        do_reset();
        rnd_v = '{1, 0, 0, 1, 1, 0, 1};
        for (int k = 0; k < 7; k++) cycle(1'(rnd_v[k]), 10 * k * 16, 1'b1);
        cycle(1'b0, 0, 1'b1);

        // Backpressure: 20 valid -> 10 kept, 8 stored, 2 dropped.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, (k + 1) * 160, 1'b0);
        chk("bp_level", int'(level), 8);
        chk("bp_drop", int'(drop_flag), 1);
        chk("bp_head", int'($signed(data_out)), 10);
        for (int k = 0; k < 8; k++) cycle(1'b0, 0, 1'b1);
        chk("bp_empty", int'(out_valid), 0);
        chk("bp_drop_sticky", int'(drop_flag), 1);
        chk("bp_last", int'($signed(data_out)), 150);

        // Asynchronous reset between edges.
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b1, rnd_data(), 1'b0);
        chk("ar_level5", int'(level), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid0", int'(out_valid), 0);
        chk("ar_level0", int'(level), 0);
        chk("ar_dout0", int'($signed(data_out)), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 320, 1'b1);
        chk("ar_phase0", int'($signed(data_out)), 20);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            cycle(1'($urandom_range(0, 3) != 0), rnd_data(), 1'($urandom_range(0, 2) != 0));
        for (int k = 0; k < 12; k++) cycle(1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
